// File: rtl/bfpu_pkg.sv
// Shared BFPU output-path types: byte width and transmitter handshake states.
// Pure definitions: no latency, no backpressure.
package bfpu_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        TX_IDLE    = 2'd0,
        TX_DRIVE   = 2'd1,
        TX_RELEASE = 2'd2
    } tx_state_e;

endpackage

// File: rtl/bfpu_out_tx_if.sv
// Core-side valid/ready byte bus plus host-side strobe/ack pin bundle.
// No latency; core backpressure via core_ready, host pacing via pin_ack.
interface bfpu_out_tx_if;
    import bfpu_pkg::*;

    logic [BYTE_W-1:0] core_data;
    logic              core_valid;
    logic              core_ready;
    logic [BYTE_W-1:0] pin_data;
    logic              pin_stb;
    logic              pin_ack;

    // Core and external host together: they offer bytes and acknowledge strobes.
    modport master (
        output core_data, core_valid, pin_ack,
        input  core_ready, pin_data, pin_stb
    );

    // The transmitter.
    modport slave (
        input  core_data, core_valid, pin_ack,
        output core_ready, pin_data, pin_stb
    );

endinterface

// File: rtl/bfpu_sync_fifo.sv
// Single-clock FIFO, head word visible on rd_data; 1-cycle write-to-read.
// Push ignored when full, pop ignored when empty; caller gates on full/empty.
module bfpu_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bfpu_out_tx.sv
// BFPU output transmitter: FIFO-buffered core bytes sent over a 4-phase strobe/ack handshake;
// strobe rises 1 cycle after a push into an empty FIFO; core stalls only when FIFO full. BFPU_TX_TIMEOUT_EN adds per-phase timeout.
module bfpu_out_tx
    import bfpu_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bfpu_out_tx_if.slave           bus,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    input  logic                   err_clr,
    output logic                   err
);

    tx_state_e         state;
    tx_state_e         state_nxt;
    logic [BYTE_W-1:0] pin_data_q;
    logic [BYTE_W-1:0] pin_data_nxt;
    logic              pin_stb_q;
    logic              pin_stb_nxt;
    logic              ack_m;
    logic              ack_s;
    logic              fifo_pop;
    logic [BYTE_W-1:0] fifo_rd;
    logic              fifo_full;
    logic              fifo_empty;
    logic              phase_expired;
    logic              timeout;

    // No push-through at full: ready depends on occupancy only, never on a same-cycle pop.
    assign bus.core_ready = !fifo_full;
    assign bus.pin_data   = pin_data_q;
    assign bus.pin_stb    = pin_stb_q;
    assign busy           = !fifo_empty || (state != TX_IDLE);

    bfpu_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (bus.core_valid && !fifo_full),
        .wr_data (bus.core_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= bus.pin_ack;
            ack_s <= ack_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= TX_IDLE;
            pin_data_q <= '0;
            pin_stb_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            pin_data_q <= pin_data_nxt;
            pin_stb_q  <= pin_stb_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pin_data_nxt = pin_data_q;
        pin_stb_nxt  = pin_stb_q;
        fifo_pop     = 1'b0;
        timeout      = 1'b0;
        case (state)
            TX_IDLE: begin
                // A stale high ack from the previous byte must be released before a new start.
                if (!fifo_empty && !ack_s) begin
                    fifo_pop     = 1'b1;
                    pin_data_nxt = fifo_rd;
                    pin_stb_nxt  = 1'b1;
                    state_nxt    = TX_DRIVE;
                end
            end
            TX_DRIVE: begin
                if (ack_s) begin
                    pin_stb_nxt = 1'b0;
                    state_nxt   = TX_RELEASE;
                end else if (phase_expired) begin
                    pin_stb_nxt = 1'b0;
                    timeout     = 1'b1;
                    state_nxt   = TX_IDLE;
                end
            end
            TX_RELEASE: begin
                if (!ack_s) begin
                    state_nxt = TX_IDLE;
                end else if (phase_expired) begin
                    timeout   = 1'b1;
                    state_nxt = TX_IDLE;
                end
            end
            default: begin
                pin_stb_nxt = 1'b0;
                state_nxt   = TX_IDLE;
            end
        endcase
    end

`ifdef BFPU_TX_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] phase_cnt;
    logic             err_q;

    assign phase_expired = (phase_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign err           = err_q;

    // Restart the count on every phase entry; it only advances while waiting on the host.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt <= '0;
        end else if ((state_nxt != state) || (state == TX_IDLE)) begin
            phase_cnt <= '0;
        end else begin
            phase_cnt <= phase_cnt + 1'b1;
        end
    end

    // A timeout in the same cycle as a clear wins, so a drop is never hidden.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    logic unused_tx;

    assign phase_expired = 1'b0;
    assign err           = 1'b0;
    assign unused_tx     = err_clr ^ timeout;
`endif

endmodule

// File: tb/tb_bfpu_out_tx.sv
module tb_bfpu_out_tx;
    import bfpu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TO    = 16;
    localparam int BOUND = 200;

    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [2:0] level;
    logic       err_clr;
    logic       err;
    int         total;
    int         bad;
    logic [7:0] exp_q[$];

    bfpu_out_tx_if bus ();

    bfpu_out_tx #(
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .busy    (busy),
        .level   (level),
        .err_clr (err_clr),
        .err     (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Core side: offer one byte and hold it until accepted; record it for the host model.
    task automatic push(input logic [7:0] b);
        int n;
        n = 0;
        bus.core_valid = 1'b1;
        bus.core_data  = b;
        while (!bus.core_ready && n < BOUND) begin
            step();
            n++;
        end
        chk("push_ready", 32'(bus.core_ready), 32'd1);
        step();
        exp_q.push_back(b);
        bus.core_valid = 1'b0;
    endtask

    // Host side: take one byte, ack after dly cycles, release ack once strobe drops.
    task automatic recv(input int dly);
        int         n;
        logic [7:0] d;
        logic [7:0] e;
        n = 0;
        while (!bus.pin_stb && n < BOUND) begin
            step();
            n++;
        end
        chk("stb_seen", 32'(bus.pin_stb), 32'd1);
        d = bus.pin_data;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 'x;
        chk("rx_data", 32'(d), 32'(e));
        for (int i = 0; i < dly; i++) begin
            step();
            chk("hold_data", 32'(bus.pin_data), 32'(d));
            chk("hold_stb", 32'(bus.pin_stb), 32'd1);
        end
        bus.pin_ack = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("stb_fall", 32'(bus.pin_stb), (k < 3) ? 32'd1 : 32'd0);
        end
        bus.pin_ack = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            step();
            chk("rel_data", 32'(bus.pin_data), 32'(d));
            chk("rel_stb", 32'(bus.pin_stb), 32'd0);
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst_n          = 1'b0;
        err_clr        = 1'b0;
        bus.core_valid = 1'b0;
        bus.core_data  = '0;
        bus.pin_ack    = 1'b0;

        // Reset values, checked before any clock edge.
        #3;
        chk("rst_stb", 32'(bus.pin_stb), 32'd0);
        chk("rst_data", 32'(bus.pin_data), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(bus.core_ready), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single byte: strobe one cycle after the push edge, busy clears on return to idle.
        bus.core_valid = 1'b1;
        bus.core_data  = 8'h41;
        step();
        bus.core_valid = 1'b0;
        exp_q.push_back(8'h41);
        chk("one_level", 32'(level), 32'd1);
        chk("one_stb0", 32'(bus.pin_stb), 32'd0);
        chk("one_busy", 32'(busy), 32'd1);
        step();
        chk("one_stb1", 32'(bus.pin_stb), 32'd1);
        chk("one_data", 32'(bus.pin_data), 32'h41);
        chk("one_level0", 32'(level), 32'd0);
        recv(5);
        chk("one_busy_rel", 32'(busy), 32'd1);
        step();
        chk("one_busy_idle", 32'(busy), 32'd0);
        chk("one_data_kept", 32'(bus.pin_data), 32'h41);

        // Full: host silent while five bytes arrive; the sixth stalls.
        for (int i = 1; i <= 5; i++) push(8'(i));
        chk("full_level", 32'(level), 32'd4);
        chk("full_ready", 32'(bus.core_ready), 32'd0);
        chk("full_stb", 32'(bus.pin_stb), 32'd1);
        chk("full_data", 32'(bus.pin_data), 32'h01);
        bus.core_valid = 1'b1;
        bus.core_data  = 8'h06;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_level", 32'(level), 32'd4);
            chk("stall_ready", 32'(bus.core_ready), 32'd0);
        end
        recv(2);
        // Pop while full must not admit the waiting byte in the same cycle.
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("pop_full_level", 32'(level), (k == 2) ? 32'd3 : 32'd4);
        end
        exp_q.push_back(8'h06);
        bus.core_valid = 1'b0;
        for (int i = 0; i < 5; i++) recv(int'($urandom_range(0, 4)));
        step();
        chk("drain_level", 32'(level), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);

        // Order and pointer wrap with random host pacing.
        fork
            begin
                for (int i = 0; i < 10; i++) push(8'h10 + 8'(i));
            end
            begin
                for (int i = 0; i < 10; i++) recv(int'($urandom_range(0, 6)));
            end
        join
        step();
        chk("stream_left", exp_q.size(), 32'd0);
        chk("stream_busy", 32'(busy), 32'd0);

        // Stale ack blocks the start until released and seen through the synchroniser.
        bus.pin_ack = 1'b1;
        step();
        step();
        step();
        push(8'h77);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stale_stb", 32'(bus.pin_stb), 32'd0);
            chk("stale_level", 32'(level), 32'd1);
        end
        bus.pin_ack = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("stale_release", 32'(bus.pin_stb), (k == 3) ? 32'd1 : 32'd0);
        end
        recv(1);
        step();

`ifdef BFPU_TX_TIMEOUT_EN
        // No ack: strobe held for TO cycles, byte dropped, next byte follows.
        push(8'hA1);
        push(8'hA2);
        for (int k = 2; k <= TO + 1; k++) begin
            step();
            chk("to_stb", 32'(bus.pin_stb), (k <= TO) ? 32'd1 : 32'd0);
            chk("to_err", 32'(err), (k > TO) ? 32'd1 : 32'd0);
        end
        void'(exp_q.pop_front());
        step();
        chk("to_next_stb", 32'(bus.pin_stb), 32'd1);
        chk("to_next_data", 32'(bus.pin_data), 32'hA2);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("to_clr", 32'(err), 32'd0);
        recv(0);
        step();
`endif

        // Asynchronous reset in the middle of a strobe.
        push(8'h55);
        push(8'h66);
        chk("mid_stb", 32'(bus.pin_stb), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stb", 32'(bus.pin_stb), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(bus.core_ready), 32'd1);
        chk("mid_rst_data", 32'(bus.pin_data), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_stb", 32'(bus.pin_stb), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
